// File: rtl/icache_axi4_refill.sv
// rtl/icache_axi4_refill.sv - AXI4 read-burst line refill engine for an instruction cache
//
// Purpose: accepts one line-refill request at a time, issues a single AXI4
// INCR (line-aligned) or WRAP (critical-word-first) burst and streams each
// returned beat to the cache line buffer together with its word index.
// Bad RRESP or misplaced RLAST make the completion report err=1; flush aborts
// the refill while still draining the burst from the interconnect.
//
// Ports:
//   aclk, aresetn              clock, asynchronous active-low reset
//   refill_req/addr/ready      miss request handshake (ready high in IDLE)
//   flush                      abort the refill in progress
//   busy                       engine not idle
//   beat_valid/idx/data        beat stream towards the line buffer
//   done, err                  one-cycle completion pulse and its error flag
//   M_AXI_AR*                  AXI4 read-address channel (master)
//   M_AXI_R*                   AXI4 read-data channel (master)

module icache_axi4_refill #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8,
    parameter int WRAP_MODE  = 0
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          refill_req,
    input  logic [ADDR_WIDTH-1:0]         refill_addr,
    output logic                          refill_ready,
    input  logic                          flush,
    output logic                          busy,
    output logic                          beat_valid,
    output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
    output logic [DATA_WIDTH-1:0]         beat_data,
    output logic                          done,
    output logic                          err,
    output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARLOCK,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic [3:0]                    M_AXI_ARQOS,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int IDXW = $clog2(LINE_WORDS);
    // One extra counter bit so the count can sit at LINE_WORDS once the line
    // is complete and further (erroneous) beats keep arriving.
    localparam int CW   = IDXW + 1;
    localparam int SZ   = $clog2(DATA_WIDTH / 8);
    localparam int LB   = $clog2(LINE_WORDS * DATA_WIDTH / 8);

    localparam logic [CW-1:0]         CNT_FULL  = CW'(LINE_WORDS);
    localparam logic [CW-1:0]         CNT_LAST  = CW'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~((ADDR_WIDTH'(1) << LB) - ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~((ADDR_WIDTH'(1) << SZ) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_AR    = 2'd1,
        S_R     = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [IDXW-1:0]         start_q, start_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    serr_q, serr_d;
    logic                    fpend_q, fpend_d;
    logic                    done_q, done_d;
    logic                    derr_q, derr_d;

    logic                    req_accept;
    logic                    r_beat;
    logic                    beat_err;

    assign req_accept = (state_q == S_IDLE) && refill_req && !flush;
    // Beats only count towards the line while in R; DRAIN just sinks data.
    assign r_beat     = (state_q == S_R) && M_AXI_RVALID;
    // RLAST must appear exactly on beat LINE_WORDS-1: catches early RLAST and,
    // once the counter saturates, a missing one.
    assign beat_err   = (M_AXI_RRESP != 2'b00) ||
                        (M_AXI_RLAST != (cnt_q == CNT_LAST));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_accept) begin
                    state_d = S_AR;
                end
            end
            S_AR: begin
                // ARVALID is never withdrawn; a flush only redirects to DRAIN
                // once the address handshake has happened.
                if (M_AXI_ARREADY) begin
                    state_d = (fpend_q || flush) ? S_DRAIN : S_R;
                end
            end
            S_R: begin
                // A burst ending in the flush cycle is already complete, so
                // return to IDLE rather than wait for an RLAST that will not come.
                if (M_AXI_RVALID && M_AXI_RLAST) begin
                    state_d = S_IDLE;
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (M_AXI_RVALID && M_AXI_RLAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        refill_ready  = (state_q == S_IDLE);
        busy          = (state_q != S_IDLE);
        M_AXI_ARVALID = (state_q == S_AR);
        M_AXI_RREADY  = (state_q == S_R) || (state_q == S_DRAIN);
        beat_valid    = r_beat && (cnt_q != CNT_FULL);
    end

    // ---------------- datapath next-state ----------------
    always_comb begin
        araddr_d = araddr_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        serr_d   = serr_q;
        fpend_d  = fpend_q;
        done_d   = 1'b0;
        derr_d   = 1'b0;

        if (req_accept) begin
            if (WRAP_MODE != 0) begin
                araddr_d = refill_addr & WORD_MASK;
                start_d  = refill_addr[SZ +: IDXW];
            end else begin
                araddr_d = refill_addr & LINE_MASK;
                start_d  = '0;
            end
            cnt_d   = '0;
            serr_d  = 1'b0;
            fpend_d = 1'b0;
        end

        if ((state_q == S_AR) && flush) begin
            fpend_d = 1'b1;
        end

        if (r_beat) begin
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (beat_err) begin
                serr_d = 1'b1;
            end
            if (M_AXI_RLAST && !flush) begin
                done_d = 1'b1;
                derr_d = serr_q || beat_err;
            end
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            araddr_q <= '0;
            start_q  <= '0;
            cnt_q    <= '0;
            serr_q   <= 1'b0;
            fpend_q  <= 1'b0;
            done_q   <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            araddr_q <= araddr_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            serr_q   <= serr_d;
            fpend_q  <= fpend_d;
            done_q   <= done_d;
            derr_q   <= derr_d;
        end
    end

    // Index wraps naturally through the IDXW-bit truncation.
    assign beat_idx      = start_q + cnt_q[IDXW-1:0];
    assign beat_data     = M_AXI_RDATA;
    assign done          = done_q;
    assign err           = derr_q;

    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARLEN   = 8'(LINE_WORDS - 1);
    assign M_AXI_ARSIZE  = 3'(SZ);
    assign M_AXI_ARBURST = (WRAP_MODE != 0) ? 2'b10 : 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0000;
    assign M_AXI_ARPROT  = 3'b100;
    assign M_AXI_ARQOS   = 4'b0000;

endmodule
